ex_muldiv_sched: RTL and testbench

//  Sequences a shared iterative multiply/divide datapath for RV32M ops issued from the EX stage.

---
 rtl/ex_muldiv_sched_pkg.sv | 30 +++
 rtl/ex_muldiv_sched_core.sv | 66 ++++++
 rtl/ex_muldiv_sched.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_sched_pkg.sv
// Shared constants for the EX-stage multiply/divide scheduler: RV32M funct3 codes,
// scheduler state encoding and operand-signedness helpers.
package ex_muldiv_sched_pkg;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_BUSY = 2'd1,
    MDS_DONE = 2'd2
  } mds_state_e;

  // MUL is treated as signed*signed; its low half is identical either way.
  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_MULHSU) ||
           (f3 == M_DIV) || (f3 == M_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sched_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or one restoring shift-subtract
// (divide) step per enabled cycle on operand magnitudes. Outputs show the post-step value.
module ex_muldiv_sched_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic              a_neg,
  input  logic              b_neg,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   mcand_reg;
  logic              div_reg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic [XLEN-1:0]   div_diff;
  logic              div_fits;

  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // Divide: the shifted partial remainder can need XLEN+1 bits when the divisor is large.
  assign div_top  = acc_reg[2*XLEN-1:XLEN-1];
  assign div_fits = div_top >= {1'b0, mcand_reg};
  assign div_diff = div_top[XLEN-1:0] - mcand_reg;
  assign div_next = div_fits ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                             : {acc_reg[2*XLEN-2:0], 1'b0};

  assign acc_next  = div_reg ? div_next : mul_next;
  assign product   = mul_next;
  assign quotient  = div_next[XLEN-1:0];
  assign remainder = div_next[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      div_reg   <= 1'b0;
    end else if (load) begin
      div_reg   <= is_div;
      mcand_reg <= is_div ? mag_b : mag_a;
      acc_reg   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (step) begin
      acc_reg   <= acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_sched.sv
// EX-stage RV32M scheduler: FSM, iteration counter, special-case detection, sign
// fix-up and the result register around the shared iterative datapath.
module ex_muldiv_sched
  import ex_muldiv_sched_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            busy_o
);

  localparam int CW = $clog2(ITER);

  mds_state_e        state_reg;
  mds_state_e        state_next;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [XLEN-1:0]   result_reg;
  logic [XLEN-1:0]   result_next;
  logic [2:0]        f3_reg;
  logic              a_neg_reg;
  logic              b_neg_reg;
  logic              load;
  logic              step;

  logic              a_neg_in;
  logic              b_neg_in;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fixed_res;

  ex_muldiv_sched_core #(.XLEN(XLEN)) muldiv_core (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .step      (step),
    .is_div    (funct3_i[2]),
    .a_neg     (a_neg_in),
    .b_neg     (b_neg_in),
    .op_a      (op1_i),
    .op_b      (op2_i),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Capture-edge decode on the live operands.
  assign a_neg_in    = op1_signed(funct3_i) & op1_i[XLEN-1];
  assign b_neg_in    = op2_signed(funct3_i) & op2_i[XLEN-1];
  assign div_zero    = funct3_i[2] & (op2_i == '0);
  assign div_ovf     = funct3_i[2] & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
  assign special_res = div_zero ? (funct3_i[1] ? op1_i : '1)
                                : (funct3_i[1] ? '0 : op1_i);

  assign mul_fix = (a_neg_reg ^ b_neg_reg) ? -product : product;
  assign quo_fix = (a_neg_reg ^ b_neg_reg) ? -quotient : quotient;
  assign rem_fix = a_neg_reg ? -remainder : remainder;

  always_comb begin
    fixed_res = mul_fix[2*XLEN-1:XLEN];
    if (f3_reg[2])
      fixed_res = f3_reg[1] ? rem_fix : quo_fix;
    else if (f3_reg == M_MUL)
      fixed_res = mul_fix[XLEN-1:0];
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    result_next = result_reg;
    load        = 1'b0;
    step        = 1'b0;
    if (flush_i) begin
      state_next = MDS_IDLE;
    end else begin
      case (state_reg)
        MDS_IDLE: begin
          if (start_i) begin
            load       = 1'b1;
            count_next = CW'(ITER - 1);
            if (div_zero || div_ovf) begin
              state_next  = MDS_DONE;
              result_next = special_res;
            end else begin
              state_next  = MDS_BUSY;
            end
          end
        end
        MDS_BUSY: begin
          step = 1'b1;
          if (count_reg == '0) begin
            state_next  = MDS_DONE;
            result_next = fixed_res;
          end else begin
            count_next  = count_reg - 1'b1;
          end
        end
        MDS_DONE: state_next = MDS_IDLE;
        default:  state_next = MDS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= MDS_IDLE;
      count_reg  <= '0;
      result_reg <= '0;
      f3_reg     <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      if (load) begin
        f3_reg    <= funct3_i;
        a_neg_reg <= a_neg_in;
        b_neg_reg <= b_neg_in;
      end
    end
  end

  // The DONE cycle releases the freeze so the op retires while the pipe advances.
  assign stall_o  = start_i & (state_reg != MDS_DONE) & ~flush_i;
  assign valid_o  = (state_reg == MDS_DONE) & ~flush_i;
  assign busy_o   = (state_reg != MDS_IDLE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_ex_muldiv_sched.sv
// Directed bench for ex_muldiv_sched: hand-computed RV32M results, latency, stall,
// flush abort, async reset and back-to-back issue.
module tb_ex_muldiv_sched;
  import ex_muldiv_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic        stall_o;
  logic [31:0] result_o;
  logic        valid_o;
  logic        busy_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  int tick = 0;

  ex_muldiv_sched #(.XLEN(32), .ITER(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .stall_o  (stall_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op with start_i held, scrambles operands after capture, and waits
  // (bounded) for the valid_o pulse. Leaves start_i high for back-to-back issue.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, output int valid_tick);
    int cyc;
    int stalls;
    bit got;
    cyc = 1;
    stalls = 0;
    got = 1'b0;
    valid_tick = 0;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    op1_i    = a;
    op2_i    = b;
    #1;
    check({tag, "_idle_at_issue"}, 32'(busy_o), 32'd0);
    while (!got && cyc < 80) begin
      if (valid_o) begin
        got = 1'b1;
        valid_tick = tick;
      end else begin
        if (stall_o) stalls++;
        @(negedge clk);
        cyc++;
        op1_i = ~a;
        op2_i = a ^ b ^ 32'h0F0F_1234;
        #1;
      end
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    $display("op %-14s f3=%0d a=0x%08h b=0x%08h -> 0x%08h after %0d cycles",
             tag, f3, a, b, result_o, cyc);
  endtask

  initial begin
    int t1;
    int t2;
    int vcount;

    #1;
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    run_op("mul_7x-3",     M_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, t1);
    run_op("mulhu_max",    M_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, t1);
    run_op("mulh_m1",      M_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, t1);
    run_op("mulhsu_m1",    M_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, t1);
    run_op("mul_shift",    M_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 34, t1);
    run_op("div_ovf",      M_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  t1);
    run_op("rem_ovf",      M_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2,  t1);
    run_op("divu_by0",     M_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 2,  t1);
    run_op("remu_by0",     M_REMU,   32'd100,        32'd0,         32'h0000_0064, 2,  t2);
    check("special_b2b_gap", 32'(t2 - t1), 32'd2);
    run_op("div_by0",      M_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2,  t1);
    run_op("rem_neg_by0",  M_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 2,  t1);
    run_op("rem_-7_2",     M_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, t1);
    run_op("div_-7_2",     M_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, t1);
    run_op("div_7_-2",     M_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, t1);
    run_op("rem_7_-2",     M_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34, t1);
    run_op("divu_bigdiv",  M_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h0000_0001, 34, t1);
    run_op("remu_bigdiv",  M_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 34, t1);
    run_op("divu_noovf",   M_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 34, t1);
    run_op("remu_noovf",   M_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34, t1);

    // Flush at busy cycle 10: abort, no pulse, then a fresh op completes.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = M_MUL;
    op1_i    = 32'd3;
    op2_i    = 32'd5;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    check("flush_to_idle", 32'(busy_o), 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid_o) vcount++;
    end
    check("flush_no_pulse", 32'(vcount), 32'd0);
    run_op("mulhu_after_fl", M_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, t1);

    // Async reset at busy cycle 5, then two back-to-back MULs.
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = M_MUL;
    op1_i    = 32'd9;
    op2_i    = 32'd9;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2;
    rstn    = 1'b0;
    start_i = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op("mul_6x7",      M_MUL,    32'd6,          32'd7,         32'd42,        34, t1);
    run_op("mul_ffff_sq",  M_MUL,    32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 34, t2);
    check("b2b_pulse_gap", 32'(t2 - t1), 32'd34);

    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("end_idle", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
